// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the instruction/data memory arbiter.
package defs;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MEM_SIZE = 1024;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data ports; on a tie the port that
// did not win last time gets the grant.
module mem_arb_pick
    import defs::*;
(
    input  logic      if_req,
    input  logic      d_req,
    input  arb_port_t last_winner,
    output arb_port_t winner,
    output logic      any_req
);

    always_comb begin
        any_req = if_req | d_req;
        if (if_req && d_req) begin
            winner = (last_winner == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            winner = PORT_D;
        end else begin
            winner = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single variable-latency memory port.
// Define ROUND_ROBIN_ARB_EN for round-robin ties; otherwise data has fixed priority.
module mem_arbiter
    import defs::*;
#(
    parameter int MEM_SIZE = defs::MEM_SIZE
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    arb_port_t last_winner;
    arb_port_t winner;
    logic      any_req;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_winner (last_winner),
        .winner      (winner),
        .any_req     (any_req)
    );

`ifdef ROUND_ROBIN_ARB_EN
    arb_port_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (if_gnt) begin
            last_d = PORT_IF;
        end else if (d_gnt) begin
            last_d = PORT_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_winner = last_q;
`else
    // A constant "fetch won last" makes the picker resolve every tie to data.
    assign last_winner = PORT_IF;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so keep them low while reset is held.
                if (any_req && !rst) begin
                    if (winner == PORT_D) begin
                        d_gnt = 1'b1;
                        if (d_addr >= MEM_LIMIT) begin
                            d_rvalid_d = 1'b1;
                            d_err_d    = 1'b1;
                        end else begin
                            state_d = D_BUSY;
                            addr_d  = d_addr;
                            we_d    = d_we;
                            wdata_d = d_wdata;
                        end
                    end else begin
                        if_gnt  = 1'b1;
                        state_d = IF_BUSY;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    d_rvalid_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, scoreboard of
// expected responses, and directed arbitration/error/reset scenarios.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] model_if_rdata = '0;
    logic [31:0] model_d_rdata  = '0;
    logic [31:0] tb_mem [0:MEM_SIZE-1];

    // Out-of-range fetch addresses read back as the inverted address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < MEM_SIZE) return tb_mem[int'(a)];
        return ~a;
    endfunction

    // Memory model: ack after lat+1 cycles of mem_req; stray_ack pulses ack while idle.
    int          lat = 1;
    logic        stray_ack = 1'b0;
    int          cnt = 0;
    logic [31:0] cap_addr;

    always @(negedge clk) begin
        if (rst) begin
            cnt     = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            cnt++;
            if (cnt == 1) cap_addr = mem_addr;
            if (cnt == lat + 1) begin
                check("mem_addr_stable", mem_addr, cap_addr);
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                if (mem_we && mem_addr < MEM_SIZE) tb_mem[int'(mem_addr)] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            cnt     = 0;
            mem_ack = stray_ack;
        end
    end

    // Monitor: pop/compare on rvalid, push expected response on each grant.
    always @(negedge clk) begin : monitor
        resp_t r;
        if (!rst) begin
            if (if_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
                end else begin
                    r = sb.pop_front();
                    check("rvalid_port", 32'(d_rvalid), 32'(r.is_d));
                    if (r.is_d) begin
                        check("d_rdata", d_rdata, r.data);
                        check("d_err", 32'(d_err), 32'(r.err));
                    end else begin
                        check("if_rdata", if_rdata, r.data);
                    end
                end
            end
            if (if_gnt && d_gnt) check("dual_gnt", 32'(if_gnt & d_gnt), 32'd0);
            if (if_gnt) begin
                model_if_rdata = mem_word(if_addr);
                sb.push_back('{1'b0, model_if_rdata, 1'b0});
            end else if (d_gnt) begin
                if (d_addr >= MEM_SIZE) begin
                    sb.push_back('{1'b1, model_d_rdata, 1'b1});
                end else if (d_we) begin
                    sb.push_back('{1'b1, model_d_rdata, 1'b0});
                end else begin
                    model_d_rdata = mem_word(d_addr);
                    sb.push_back('{1'b1, model_d_rdata, 1'b0});
                end
            end
        end
    end

    task automatic wait_gnt(input bit is_d, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt : if_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mem_req) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_gnt(is_d, tag);
        wait_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ngnt;
        int  seen;
        bit  exp_d;

        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        for (int i = 0; i < MEM_SIZE; i++) tb_mem[i] = 32'hC0DE_0000 + 32'(i);
        tb_mem[4]  = 32'h000140EF;
        tb_mem[20] = 32'h12345678;

        // Reset values, with requests already pending to show gnt stays low.
        rst = 1'b1;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'd8; d_addr = 32'd12;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_gnt",    32'(if_gnt),    32'd0);
        check("rst_d_gnt",     32'(d_gnt),     32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_d_rvalid",  32'(d_rvalid),  32'd0);
        check("rst_d_err",     32'(d_err),     32'd0);
        check("rst_if_rdata",  if_rdata,       32'd0);
        check("rst_d_rdata",   d_rdata,        32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);

        // Both ports requesting continuously, straight out of reset.
        lat = 0;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef ROUND_ROBIN_ARB_EN
        exp_d = 1'b0;
`else
        exp_d = 1'b1;
`endif
        ngnt = 0;
        for (int i = 0; i < 100 && ngnt < 6; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                check("arb_winner_is_d", 32'(d_gnt), 32'(exp_d));
                if (ngnt > 0) check("gnt_with_rvalid", 32'(if_rvalid | d_rvalid), 32'd1);
                ngnt++;
`ifdef ROUND_ROBIN_ARB_EN
                exp_d = ~exp_d;
`endif
            end
        end
        check("arb_grant_count", 32'(ngnt), 32'd6);
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_gnt(1'b0, "if_after_d_drop");
        wait_idle("arb");

        // Single fetch, two-cycle memory latency, cycle-exact timing.
        lat = 2;
        if_req = 1'b1; if_addr = 32'd4;
        @(negedge clk);
        check("c0_if_gnt",  32'(if_gnt),  32'd1);
        check("c0_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("busy_mem_req",   32'(mem_req),   32'd1);
            check("busy_if_rvalid", 32'(if_rvalid), 32'd0);
        end
        @(negedge clk);
        check("c4_if_rvalid", 32'(if_rvalid), 32'd1);
        check("c4_if_rdata",  if_rdata,       32'h000140EF);
        check("c4_mem_req",   32'(mem_req),   32'd0);
        @(posedge clk); #1;
        wait_idle("fetch4");

        // Data read, then write to the same word (d_rdata must hold), then read back.
        lat = 1;
        xfer(1'b1, 1'b0, 32'd20, 32'd0, "d_rd20");
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'hDEADBEEF;
        wait_gnt(1'b1, "d_wr20");
        @(negedge clk);
        check("wr_mem_req",   32'(mem_req), 32'd1);
        check("wr_mem_we",    32'(mem_we),  32'd1);
        check("wr_mem_addr",  mem_addr,     32'd20);
        check("wr_mem_wdata", mem_wdata,    32'hDEADBEEF);
        wait_idle("d_wr20");
        check("wr_d_rdata_held", d_rdata, 32'h12345678);
        d_we = 1'b0;
        xfer(1'b1, 1'b0, 32'd20, 32'd0, "d_rd20_back");

        // Out-of-range data address: no memory access, error response next cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'(MEM_SIZE);
        @(negedge clk);
        check("oor_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("oor_mem_req",  32'(mem_req),  32'd0);
        check("oor_d_rvalid", 32'(d_rvalid), 32'd1);
        check("oor_d_err",    32'(d_err),    32'd1);
        @(negedge clk);
        check("oor_d_rvalid_pulse", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        wait_idle("oor");

        // Fetch beyond MEM_SIZE goes to memory unchanged.
        if_req = 1'b1; if_addr = 32'd2000;
        wait_gnt(1'b0, "if_far");
        @(negedge clk);
        check("far_mem_req",  32'(mem_req), 32'd1);
        check("far_mem_addr", mem_addr,     32'd2000);
        wait_idle("if_far");

        // mem_ack while idle must not produce a response.
        stray_ack = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(if_rvalid | d_rvalid);
        end
        stray_ack = 1'b0;
        check("idle_ack_ignored", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // Short random mix of single-port traffic.
        for (int k = 0; k < 10; k++) begin
            lat = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 5) == 0)
                    xfer(1'b1, 1'b0, 32'(MEM_SIZE) + 32'($urandom_range(0, 99)), 32'd0, "rnd_oor");
                else
                    xfer(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(32, MEM_SIZE - 1)),
                         $urandom, "rnd_d");
            end else begin
                xfer(1'b0, 1'b0, 32'($urandom_range(32, MEM_SIZE - 1)), 32'd0, "rnd_if");
            end
        end

        // Reset one cycle after mem_req rises: transaction dropped, no rvalid.
        lat = 6;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd20;
        wait_gnt(1'b1, "rst_mid");
        @(negedge clk);
        check("mid_mem_req_up", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        model_if_rdata = '0;
        model_d_rdata  = '0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_d_rdata", d_rdata,      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(if_rvalid | d_rvalid);
        end
        check("no_rvalid_after_rst", 32'(seen), 32'd0);
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 32'd4, 32'd0, "post_rst_fetch");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have a parameter MEM_SIZE, default defs::MEM_SIZE, giving the number of addressable 32-bit words.
REQ-002 SHALL have ports clk (input, 1, sole clock, rising edge) and rst (input, 1, asynchronous active-high reset).
REQ-003 SHALL have ports if_req (in, 1, fetch request), if_addr (in, 32, word address), if_gnt (out, 1, request accepted), if_rvalid (out, 1, response pulse) and if_rdata (out, 32, instruction word).
REQ-004 SHALL have ports d_req (in, 1), d_we (in, 1, write), d_addr (in, 32), d_wdata (in, 32), d_gnt (out, 1), d_rvalid (out, 1), d_rdata (out, 32) and d_err (out, 1, address-range error, valid with d_rvalid).
REQ-005 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32) and mem_ack (in, 1, completion, variable latency of at least 1 cycle).

Function
REQ-006 SHALL implement the states IDLE, IF_BUSY and D_BUSY, with only one memory transaction outstanding at any time.
REQ-007 SHALL assert if_gnt/d_gnt combinationally, only in IDLE, and for at most one port per cycle; a request SHALL be accepted in the cycle its gnt is high.
REQ-008 SHALL, on acceptance, register the address, we and wdata and move to IF_BUSY or D_BUSY on the next edge.
REQ-009 SHALL hold mem_req high with stable mem_addr/mem_we/mem_wdata in the BUSY states until the cycle in which mem_ack is high, inclusive.
REQ-010 SHALL, on mem_ack, return to IDLE and, on the next cycle, pulse the owner's rvalid for one cycle with rdata registered from mem_rdata.
REQ-011 SHALL hold rdata between rvalid pulses, and SHALL NOT update d_rdata on a write completion, although d_rvalid still pulses.
REQ-012 SHALL, for a data request with d_addr >= MEM_SIZE, grant it, issue no mem_req, stay in IDLE, and pulse d_rvalid with d_err=1 on the next cycle.
REQ-013 SHALL treat fetch addresses >= MEM_SIZE as legal and pass them through to memory.
REQ-014 SHALL ignore mem_ack while in IDLE.
REQ-015 SHALL allow a new grant in the same cycle as the previous response's rvalid.
REQ-016 SHALL ignore requests from a port during that port's own outstanding transaction.

Reset
REQ-017 SHALL, on rst, asynchronously force IDLE and drive every output low or zero, including rdata, err and gnt.
REQ-018 SHALL set the arbitration history to "last winner = data" on reset.
REQ-019 SHALL, if reset is asserted mid-transaction, drop the transaction, deassert mem_req immediately and produce no rvalid.

Configuration
REQ-020 SHALL use round-robin arbitration when ROUND_ROBIN_ARB_EN is defined: on simultaneous requests the port not granted last wins, and the last-winner register updates on every grant.
REQ-021 SHALL, when ROUND_ROBIN_ARB_EN is undefined, give the data port fixed priority over fetch and contain no last-winner register.

Structure
REQ-022 SHALL place arb_state_t (IDLE, IF_BUSY, D_BUSY), arb_port_t (PORT_IF, PORT_D) and ADDR_W=32/DATA_W=32 in package defs, beside MEM_SIZE.
REQ-023 SHALL put the winner selection in one combinational sub-module, mem_arb_pick, with inputs if_req, d_req and last winner, and output winner and any-request.

Verification
REQ-024 SHALL cover: if_req with if_addr=4, mem_ack 2 cycles after mem_req, mem_rdata=32'h000140EF -> if_gnt in cycle 0, mem_req in cycles 1-3, if_rvalid in cycle 4 with if_rdata=32'h000140EF.
REQ-025 SHALL cover: if_req and d_req both high after reset, with ROUND_ROBIN_ARB_EN defined -> IF granted first, then D, then IF again while both requests stay high.
REQ-026 SHALL cover: the same stimulus without the macro -> D granted every time, and if_gnt only when d_req is low.
REQ-027 SHALL cover: d_req with d_we=1, d_addr=20 and d_wdata=32'hDEADBEEF -> mem_we=1, mem_wdata=32'hDEADBEEF, d_rvalid pulse, d_rdata unchanged and d_err=0.
REQ-028 SHALL cover: d_req with d_addr=MEM_SIZE -> mem_req stays low, and d_rvalid=1 with d_err=1 on the next cycle.
REQ-029 SHALL cover: rst asserted one cycle after mem_req rises -> mem_req low in the same cycle, no rvalid ever, and a fresh grant accepted after reset is released.
